// File: rtl/bcd_to_binary_seq_pkg.sv
// Shared types and constants for the sequential BCD-to-binary decoder.
// State encoding, digit limit and step-counter sizing.
package bcd_to_binary_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE_ERR
  } state_t;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  function automatic int step_w(input int bin_w);
    return (bin_w > 1) ? $clog2(bin_w) : 1;
  endfunction

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// Start/busy/done handshake bundle for the BCD-to-binary decoder.
// The requester uses master, the decoder uses slave.
interface bcd_to_binary_seq_if #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
);

  logic                  start_pi;
  logic [4*DIGITS-1:0]   bcd_pi;
  logic                  busy_po;
  logic                  done_po;
  logic [BIN_W-1:0]      bin_po;
  logic                  err_po;

  modport master (
    output start_pi,
    output bcd_pi,
    input  busy_po,
    input  done_po,
    input  bin_po,
    input  err_po
  );

  modport slave (
    input  start_pi,
    input  bcd_pi,
    output busy_po,
    output done_po,
    output bin_po,
    output err_po
  );

endinterface

// File: rtl/bcd_to_binary_seq_sub3.sv
// Nibble corrector for reverse double-dabble: subtract 3 from 8 and up.
// Inverse of the add-3 step used on the binary-to-BCD path.
module bcd_sub3 (
  input  logic [3:0] nib,
  output logic [3:0] fixed
);

  // Values 0..4 pass through; 8 and above come back down by 3.
  always_comb begin
    fixed = nib;
    if (nib >= 4'd8) fixed = nib - 4'd3;
  end

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary decoder, shift-right / subtract-3 per clock.
// Invalid digits short-circuit to an error result after one cycle.
module bcd_to_binary_seq
  import bcd_to_binary_seq_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input logic clk_pi,
  input logic rst_n_pi,
  bcd_to_binary_seq_if.slave bus
);

  localparam int SW  = step_w(BIN_W);
  localparam int W_W = 4*DIGITS + BIN_W;

  state_t           state;
  logic [W_W-1:0]   work;
  logic [W_W-1:0]   shifted;
  logic [W_W-1:0]   stepped;
  logic [SW-1:0]    step;
  logic             busy;
  logic             done;
  logic [BIN_W-1:0] bin;
  logic             err;
  logic             bad;

  assign shifted = work >> 1;
  assign stepped[BIN_W-1:0] = shifted[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_fix
    bcd_sub3 u_sub3 (
      .nib   (shifted[BIN_W+4*g +: 4]),
      .fixed (stepped[BIN_W+4*g +: 4])
    );
  end

  // Flag any input nibble above 9.
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.bcd_pi[4*i +: 4] > BCD_MAX_DIGIT) bad = 1'b1;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      state <= IDLE;
      work  <= '0;
      step  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bin   <= '0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start_pi) begin
            busy <= 1'b1;
            if (bad) begin
              state <= DONE_ERR;
            end else begin
              work  <= {bus.bcd_pi, {BIN_W{1'b0}}};
              step  <= '0;
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work <= stepped;
          step <= step + 1'b1;
          if (step == SW'(BIN_W-1)) begin
            bin   <= stepped[BIN_W-1:0];
            err   <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        DONE_ERR: begin
          bin   <= '0;
          err   <= 1'b1;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy_po = busy;
  assign bus.done_po = done;
  assign bus.bin_po  = bin;
  assign bus.err_po  = err;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed bench for bcd_to_binary_seq: 2-digit and 3-digit instances.
// Inputs change 1ns after posedge; outputs sampled there too.
module tb_bcd_to_binary_seq;

  logic clk;
  logic rst_n;
  int   vectors;
  int   errors;

  bcd_to_binary_seq_if #(.DIGITS(2), .BIN_W(7))  bus_a ();
  bcd_to_binary_seq_if #(.DIGITS(3), .BIN_W(10)) bus_b ();

  bcd_to_binary_seq #(.DIGITS(2), .BIN_W(7)) dut_a (
    .clk_pi   (clk),
    .rst_n_pi (rst_n),
    .bus      (bus_a)
  );

  bcd_to_binary_seq #(.DIGITS(3), .BIN_W(10)) dut_b (
    .clk_pi   (clk),
    .rst_n_pi (rst_n),
    .bus      (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accept on next edge, then count edges until done (lat=-1 on timeout).
  task automatic conv_a(input logic [7:0] b, output logic [6:0] bin,
                        output logic e, output int lat);
    bus_a.start_pi = 1'b1;
    bus_a.bcd_pi   = b;
    tick();
    bus_a.start_pi = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (lat < 0) begin
        tick();
        if (bus_a.done_po) lat = i;
      end
    end
    bin = bus_a.bin_po;
    e   = bus_a.err_po;
  endtask

  task automatic conv_b(input logic [11:0] b, output logic [9:0] bin,
                        output logic e, output int lat);
    bus_b.start_pi = 1'b1;
    bus_b.bcd_pi   = b;
    tick();
    bus_b.start_pi = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (lat < 0) begin
        tick();
        if (bus_b.done_po) lat = i;
      end
    end
    bin = bus_b.bin_po;
    e   = bus_b.err_po;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus_a.start_pi = 1'b0;
    bus_a.bcd_pi   = '0;
    bus_b.start_pi = 1'b0;
    bus_b.bcd_pi   = '0;
    tick();
    tick();
    vectors++;
    if ({bus_a.busy_po, bus_a.done_po, bus_a.err_po} !== 3'b000) begin
      errors++;
      $display("FAIL reset_a_flags got=%b want=000",
               {bus_a.busy_po, bus_a.done_po, bus_a.err_po});
    end
    vectors++;
    if (bus_a.bin_po !== 7'd0) begin
      errors++;
      $display("FAIL reset_a_bin got=%0d want=0", bus_a.bin_po);
    end
    vectors++;
    if ({bus_b.busy_po, bus_b.done_po, bus_b.err_po, bus_b.bin_po} !== 13'd0) begin
      errors++;
      $display("FAIL reset_b got=%h want=0",
               {bus_b.busy_po, bus_b.done_po, bus_b.err_po, bus_b.bin_po});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    int busy_n;
    int lat;
    bus_a.start_pi = 1'b1;
    bus_a.bcd_pi   = 8'h59;
    tick();
    bus_a.start_pi = 1'b0;
    busy_n = 0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (lat < 0) begin
        if (bus_a.busy_po) busy_n++;
        tick();
        if (bus_a.done_po) lat = i;
      end
    end
    vectors++;
    if (busy_n !== 7) begin
      errors++;
      $display("FAIL basic_busy_cycles got=%0d want=7", busy_n);
    end
    vectors++;
    if (lat !== 7) begin
      errors++;
      $display("FAIL basic_latency got=%0d want=7", lat);
    end
    vectors++;
    if (bus_a.bin_po !== 7'd59 || bus_a.err_po !== 1'b0) begin
      errors++;
      $display("FAIL basic_59 got=%0d err=%b want=59 err=0",
               bus_a.bin_po, bus_a.err_po);
    end
    vectors++;
    if (bus_a.busy_po !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_at_done got=%b want=0", bus_a.busy_po);
    end
    tick();
    vectors++;
    if (bus_a.done_po !== 1'b0 || bus_a.bin_po !== 7'd59) begin
      errors++;
      $display("FAIL basic_pulse done=%b bin=%0d want done=0 bin=59",
               bus_a.done_po, bus_a.bin_po);
    end
  endtask

  task automatic test_back_to_back;
    int lat1;
    int lat2;
    logic [6:0] bin1;
    bus_a.start_pi = 1'b1;
    bus_a.bcd_pi   = 8'h99;
    tick();
    lat1 = -1;
    bin1 = '0;
    for (int i = 1; i <= 20; i++) begin
      if (lat1 < 0) begin
        tick();
        if (bus_a.done_po) begin
          lat1 = i;
          bin1 = bus_a.bin_po;
        end
      end
    end
    bus_a.bcd_pi = 8'h00;
    tick();
    lat2 = -1;
    for (int i = 1; i <= 20; i++) begin
      if (lat2 < 0) begin
        tick();
        if (bus_a.done_po) lat2 = i;
      end
    end
    bus_a.start_pi = 1'b0;
    vectors++;
    if (lat1 !== 7 || bin1 !== 7'd99) begin
      errors++;
      $display("FAIL b2b_first lat=%0d bin=%0d want lat=7 bin=99", lat1, bin1);
    end
    vectors++;
    if (lat2 !== 7 || bus_a.bin_po !== 7'd0) begin
      errors++;
      $display("FAIL b2b_second lat=%0d bin=%0d want lat=7 bin=0",
               lat2, bus_a.bin_po);
    end
    tick();
    tick();
    vectors++;
    if (bus_a.busy_po !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_third busy=%b want=0", bus_a.busy_po);
    end
  endtask

  task automatic test_invalid;
    logic [6:0] bin;
    logic e;
    int lat;
    conv_a(8'h5A, bin, e, lat);
    vectors++;
    if (lat !== 1 || e !== 1'b1 || bin !== 7'd0) begin
      errors++;
      $display("FAIL invalid_5A lat=%0d err=%b bin=%0d want lat=1 err=1 bin=0",
               lat, e, bin);
    end
    tick();
    conv_a(8'hC3, bin, e, lat);
    vectors++;
    if (lat !== 1 || e !== 1'b1 || bin !== 7'd0) begin
      errors++;
      $display("FAIL invalid_C3 lat=%0d err=%b bin=%0d want lat=1 err=1 bin=0",
               lat, e, bin);
    end
    tick();
    conv_a(8'h12, bin, e, lat);
    vectors++;
    if (lat !== 7 || e !== 1'b0 || bin !== 7'd12) begin
      errors++;
      $display("FAIL invalid_then_12 lat=%0d err=%b bin=%0d want lat=7 err=0 bin=12",
               lat, e, bin);
    end
    tick();
  endtask

  task automatic test_ignore;
    int lat;
    int extra;
    bus_a.start_pi = 1'b1;
    bus_a.bcd_pi   = 8'h42;
    tick();
    bus_a.start_pi = 1'b0;
    tick();
    tick();
    bus_a.start_pi = 1'b1;
    bus_a.bcd_pi   = 8'h07;
    tick();
    bus_a.start_pi = 1'b0;
    lat = bus_a.done_po ? 3 : -1;
    for (int i = 4; i <= 20; i++) begin
      if (lat < 0) begin
        tick();
        if (bus_a.done_po) lat = i;
      end
    end
    vectors++;
    if (lat !== 7 || bus_a.bin_po !== 7'd42) begin
      errors++;
      $display("FAIL ignore_result lat=%0d bin=%0d want lat=7 bin=42",
               lat, bus_a.bin_po);
    end
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus_a.done_po || bus_a.busy_po) extra++;
    end
    vectors++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL ignore_no_second got=%0d busy/done cycles want=0", extra);
    end
  endtask

  task automatic test_reset_mid;
    logic [6:0] bin;
    logic e;
    int lat;
    int extra;
    bus_a.start_pi = 1'b1;
    bus_a.bcd_pi   = 8'h37;
    tick();
    bus_a.start_pi = 1'b0;
    tick();
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus_a.busy_po, bus_a.done_po, bus_a.bin_po} !== 9'd0) begin
      errors++;
      $display("FAIL reset_mid_async busy=%b done=%b bin=%0d want 0/0/0",
               bus_a.busy_po, bus_a.done_po, bus_a.bin_po);
    end
    tick();
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus_a.done_po || bus_a.busy_po) extra++;
    end
    vectors++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done got=%0d busy/done cycles want=0", extra);
    end
    conv_a(8'h37, bin, e, lat);
    vectors++;
    if (lat !== 7 || bin !== 7'd37 || e !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_retry lat=%0d bin=%0d err=%b want lat=7 bin=37 err=0",
               lat, bin, e);
    end
    tick();
  endtask

  task automatic test_sweep;
    logic [6:0] bin;
    logic e;
    int lat;
    logic [7:0] b;
    for (int t = 0; t < 10; t++) begin
      for (int o = 0; o < 10; o++) begin
        b = {4'(t), 4'(o)};
        conv_a(b, bin, e, lat);
        vectors++;
        if (lat !== 7 || e !== 1'b0 || bin !== 7'(10*t + o)) begin
          errors++;
          $display("FAIL sweep_%h lat=%0d err=%b bin=%0d want lat=7 err=0 bin=%0d",
                   b, lat, e, bin, 10*t + o);
        end
        tick();
      end
    end
  endtask

  task automatic test_wide;
    logic [9:0] bin;
    logic e;
    int lat;
    logic [11:0] vec [3];
    int want [3];
    vec[0] = 12'h999; want[0] = 999;
    vec[1] = 12'h512; want[1] = 512;
    vec[2] = 12'h100; want[2] = 100;
    for (int k = 0; k < 3; k++) begin
      conv_b(vec[k], bin, e, lat);
      vectors++;
      if (lat !== 10 || e !== 1'b0 || bin !== 10'(want[k])) begin
        errors++;
        $display("FAIL wide_%h lat=%0d err=%b bin=%0d want lat=10 err=0 bin=%0d",
                 vec[k], lat, e, bin, want[k]);
      end
      tick();
    end
    conv_b(12'h9F1, bin, e, lat);
    vectors++;
    if (lat !== 1 || e !== 1'b1 || bin !== 10'd0) begin
      errors++;
      $display("FAIL wide_invalid lat=%0d err=%b bin=%0d want lat=1 err=1 bin=0",
               lat, e, bin);
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_invalid();
    test_ignore();
    test_reset_mid();
    test_sweep();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary_seq.md
Name: bcd_to_binary_seq

Overview:
Sequential BCD-to-binary decoder using reverse double-dabble (shift-right, subtract-3). It is the inverse of the existing binary-to-BCD path. It converts keypad- or switch-entered decimal digits, such as alarm minutes or hours, back into the binary counts held by the clock and alarm FSMs. Handshake is start/busy/done, with an invalid-digit error flag.

Parameters:
DIGITS, 2, number of BCD nibbles on bcd_pi
BIN_W, 7, binary result width; must satisfy 2^BIN_W > 10^DIGITS - 1 (default covers 0..99)

Ports:
clk_pi  in  1  system clock; all state updates on posedge
rst_n_pi  in  1  reset, asynchronous, active-low
start_pi  in  1  request conversion; sampled only in IDLE
bcd_pi  in  4*DIGITS  packed BCD, nibble 0 = ones digit; sampled on the accepting edge
busy_po  out  1  high from the accepting edge until done_po is asserted
done_po  out  1  one-cycle pulse marking bin_po/err_po valid
bin_po  out  BIN_W  binary result; held until the next done_po
err_po  out  1  set with done_po if any input nibble > 9; held until next done_po

Behaviour:
- Clock and reset: one clock, clk_pi. Reset is asynchronous and active-low on rst_n_pi.
- Reset values: state=IDLE, busy_po=0, done_po=0, bin_po=0, err_po=0, shift register=0, step counter=0.
- Datapath: working register W = {bcd_field[4*DIGITS-1:0], bin_field[BIN_W-1:0]}.
- One step:
  - W <= W >> 1 (zero fill at MSB; bcd LSB moves into bin MSB).
  - Then every shifted BCD nibble >= 8 has 3 subtracted (4-bit, no borrow across nibbles).
- States:
  - IDLE: if start_pi=1 on an edge, check the nibbles.
    - Any nibble > 9: go to DONE_ERR directly.
    - Otherwise: W <= {bcd_pi, 0}, step <= 0, busy_po <= 1, go to SHIFT.
    - start_pi=0: stay in IDLE.
  - SHIFT: one step per clock; step <= step+1. On the edge where step == BIN_W-1 (the BIN_W-th step):
    - bin_po <= next bin_field, err_po <= 0, done_po <= 1, busy_po <= 0.
    - Go to IDLE.
  - DONE_ERR (entered only from IDLE):
    - On the accepting edge: busy_po <= 1.
    - Next edge: bin_po <= 0, err_po <= 1, done_po <= 1, busy_po <= 0, go to IDLE.
- Latency: start accepted at edge t.
  - Valid input: done_po high during the cycle after edge t+BIN_W, so busy for BIN_W cycles (7 at default).
  - Invalid input: done_po high after edge t+1.
- done_po is cleared on the edge following its assertion; it is never high for two consecutive cycles.
- start_pi while busy_po=1: ignored, with no queuing.
- start_pi high in the same cycle done_po is high (state is IDLE): accepted normally (back-to-back conversions).
- start_pi held high continuously: a new conversion begins each time IDLE is reached.
- bcd_pi changes during SHIFT: no effect.
- Reset asserted mid-conversion: immediate return to IDLE with all reset values. Result is lost and no done_po is issued.
- Width rule: the final BCD field is all zeros for valid input; no overflow is possible under the parameter constraint.
- Leading zeros are legal, e.g. 8'h05 -> 5.

Decomposition:
- Shared package holds:
  - the state enum {IDLE, SHIFT, DONE_ERR};
  - the constant BCD_MAX_DIGIT = 4'd9;
  - the function computing the step-counter width, $clog2(BIN_W).
- One natural sub-module, bcd_sub3: a 4-bit combinational nibble corrector, the inverse of bcd_add3.
  - in >= 8 -> in-3; 0..4 pass through.
  - Instantiated DIGITS times on the shifted BCD field.

Test Plan:
- Reset, then start with bcd_pi=8'h59 -> busy 7 cycles; done_po single pulse; bin_po=59; err_po=0.
- bcd_pi=8'h99 then 8'h00, back-to-back with start held high across done -> bin_po=99, then bin_po=0. Each done is exactly 7 cycles after its accept, with no idle gap.
- bcd_pi=8'h5A (invalid ones nibble) -> done_po one cycle after the accept edge; err_po=1; bin_po=0. A following 8'h12 gives bin_po=12 and clears err_po=0.
- Start 8'h42; pulse start_pi again with 8'h07 at cycle 3 of busy -> second start ignored; bin_po=42 only; no second done.
- Start 8'h37; assert rst_n_pi low asynchronously at cycle 4 (mid-clock) -> busy_po/done_po/bin_po go to 0 before the next edge. No done after release; a new start 8'h37 yields 37.
- Exhaustive sweep of all 100 valid 2-digit inputs (BIN_W=7) and DIGITS=3/BIN_W=10 spot checks (999, 512, 100) -> bin_po equals the decimal value; done latency = BIN_W.
